transmitter: RTL
================

Name: transmitter

Overview:
UART serial transmitter; the transmit-side counterpart of the team's UART receiver, sharing its frame format and baud parameters.
- Accepts a SIZE-bit word over a ready/start handshake.
- Serialises it onto tx as: 1 start bit (0), SIZE data bits LSB first, 1 stop bit (1).
- Each bit lasts exactly BAUD_COUNT clocks.
- Used standalone or in loopback against the receiver in the UART bench.

Parameters:
SIZE, 8, data word width in bits
BAUD_RATE, 115200, line bit rate
CLK_FREQ, 1000000, clk frequency in Hz
BAUD_COUNT, CLK_FREQ/BAUD_RATE (=8), clocks per bit; must be >= 2

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
tx_start  input  1  request to send data_in; sampled only when tx_ready=1
data_in  input  SIZE  word to transmit; captured on the accepting edge
tx_ready  output  1  block can accept a word this cycle
tx  output  1  serial line, registered, idle-high
tx_busy  output  1  frame in progress (START/DATA/STOP)
tx_done  output  1  one-cycle pulse when the stop bit completes

Behaviour:
- Reset (rst=0, async): tx=1, tx_busy=0, tx_done=0, state IDLE, all counters and the shift register cleared. tx_ready=1 after rst deasserts.
- Reset mid-frame: the line returns high immediately and the frame is abandoned with no tx_done.
- FSM states: IDLE, START, DATA, STOP.
- Accept event = tx_start && tx_ready at a rising edge. On that edge:
  - data_in is latched into the shift register;
  - tx<=0, state<=START, baud counter<=0, tx_busy<=1.
  - Latency: tx falls on the accepting edge itself (zero-cycle output delay beyond the register).
- tx_ready is combinational:
  - 1 in IDLE;
  - 1 in the last cycle of STOP (baud counter==BAUD_COUNT-1);
  - 0 otherwise.
- tx_start while tx_ready=0 is ignored; no queueing. data_in changes after acceptance have no effect.
- START: hold tx=0 for BAUD_COUNT cycles. At baud counter==BAUD_COUNT-1: tx<=bit0, state<=DATA, bit counter<=0, baud counter<=0.
- DATA: each bit is held BAUD_COUNT cycles. At the end of each bit, shift right and drive the next bit. After bit SIZE-1 completes: tx<=1, state<=STOP.
- STOP: hold tx=1 for BAUD_COUNT cycles. At the final cycle, tx_done<=1 for exactly one cycle, then:
  - if an accept occurs on the same edge: state<=START, tx<=0, new word latched (back-to-back frame, zero idle gap, tx_busy stays 1);
  - otherwise: state<=IDLE, tx_busy<=0, tx stays 1.
- Frame length is exactly (SIZE+2)*BAUD_COUNT clocks from the accepting edge to the tx_done edge.
- Width rules:
  - baud counter is $clog2(BAUD_COUNT) bits and wraps to 0 only by explicit clear;
  - bit counter is $clog2(SIZE) bits (min 1);
  - no arithmetic overflow is permitted at the terminal count.
- tx_busy=1 exactly while state != IDLE.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, STOP), 2 bits;
  - default SIZE/BAUD_RATE/CLK_FREQ constants;
  - a function computing BAUD_COUNT and counter widths. The receiver is to share this package.
- One natural sub-module, uart_baud_cnt:
  - clears on a load/clear input;
  - asserts bit_end when count==BAUD_COUNT-1;
  - reusable by the receiver.

Test Plan:
1. SIZE=8, BAUD_COUNT=8; send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each held 8 clks; tx_done pulses once, 80 clks after accept; tx_busy high for those 80 clks.
2. Loopback tx into the receiver; send 0x3C then 0xFF -> receiver data_out=0x3C then 0xFF, rx_done each time; no framing loss.
3. Hold tx_start=1 with 0x00 then 0x81 -> second start bit begins on the edge after the first stop bit's final cycle; no extra idle cycles; 160 clks total; two tx_done pulses 80 clks apart.
4. Pulse tx_start with 0x12 during DATA of frame 0x55 -> ignored; only 0x55 transmitted, tx_ready=0 at that cycle.
5. Assert rst=0 mid-DATA of 0xC3 (asynchronously, between edges) -> tx=1 and tx_busy=0 immediately; no tx_done; after release, sending 0x01 produces a clean frame.
6. Change data_in every cycle after accepting 0x96 -> line still carries 0x96 (0,0,1,1,0,1,0,0,1,1).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default line parameters, sizing helpers.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package uart_pkg;

   // Frame phases shared by the transmitter and the receiver
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   // Default frame and line settings; the integer divide truncates, so 1 MHz / 115200 gives 8
   localparam int DEF_SIZE      = 8;
   localparam int DEF_BAUD_RATE = 115200;
   localparam int DEF_CLK_FREQ  = 1000000;

   // Clocks per bit. The division truncates, so the real bit rate is slightly faster than nominal.
   function automatic int baud_count(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

   // Counter width able to hold 0..n-1. Never narrower than one bit, so a one-bit word still gets a counter.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Clocks from the accepting edge to the tx_done edge: start bit, data bits and stop bit
   function automatic int frame_clocks(input int size, input int bc);
      return (size + 2) * bc;
   endfunction

endpackage

// File: rtl/transmitter_if.sv
// Word handshake and serial-line bundle between a UART transmitter and its user.
// Latency: none, wiring only.
// Backpressure: user may raise tx_start at any time, but a word is taken only while tx_ready is high.
interface transmitter_if
   import uart_pkg::*;
#(
   parameter int SIZE = DEF_SIZE
);
   logic            tx_start;
   logic [SIZE-1:0] data_in;
   logic            tx_ready;
   logic            tx;
   logic            tx_busy;
   logic            tx_done;

   // User side: offers words and watches the line and the status flags
   modport master (
      output tx_start,
      output data_in,
      input  tx_ready,
      input  tx,
      input  tx_busy,
      input  tx_done
   );

   // Transmitter side
   modport slave (
      input  tx_start,
      input  data_in,
      output tx_ready,
      output tx,
      output tx_busy,
      output tx_done
   );
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts clocks within one bit and flags the final clock of the bit.
// Latency: bit_end is combinational from the count; the count advances one step per enabled clock.
// Backpressure: none; the owner clears the count at each bit boundary.
module uart_baud_cnt #(
   parameter int BAUD_COUNT = 8,
   parameter int W          = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic bit_end
);
   localparam logic [W-1:0] LAST = W'(BAUD_COUNT - 1);
   localparam logic [W-1:0] ONE  = W'(1);

   logic [W-1:0] count;

   // Final clock of the current bit period
   assign bit_end = (count == LAST);

   // The count stops at the terminal value and only clr returns it to zero, so it can never overflow
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && !bit_end) begin
         count <= count + ONE;
      end
   end
endmodule

// File: rtl/transmitter.sv
// UART transmitter: 1 start bit, SIZE data bits sent LSB first, 1 stop bit, each bit BAUD_COUNT clocks.
// Latency: tx falls on the accepting edge; tx_done pulses (SIZE+2)*BAUD_COUNT clocks after that edge.
// Backpressure: tx_ready is high in IDLE and in the last STOP clock; tx_start is ignored otherwise, nothing is queued.
module transmitter
   import uart_pkg::*;
#(
   parameter int SIZE      = DEF_SIZE,
   parameter int BAUD_RATE = DEF_BAUD_RATE,
   parameter int CLK_FREQ  = DEF_CLK_FREQ
) (
   input  logic          clk,
   input  logic          rst,
   transmitter_if.slave  bus
);
   // BAUD_COUNT must be at least 2 so that bit_end is never true with the counter held at zero in IDLE
   localparam int BAUD_COUNT = baud_count(CLK_FREQ, BAUD_RATE);
   localparam int BCW        = cnt_width(BAUD_COUNT);
   localparam int BW         = cnt_width(SIZE);

   localparam logic [BW-1:0] LAST_BIT = BW'(SIZE - 1);
   localparam logic [BW-1:0] BIT_ONE  = BW'(1);

   uart_state_t     state;
   uart_state_t     state_nxt;
   logic [SIZE-1:0] shreg;
   logic [SIZE-1:0] shreg_nxt;
   logic [SIZE-1:0] shifted;
   logic [BW-1:0]   bit_cnt;
   logic [BW-1:0]   bit_cnt_nxt;
   logic            tx_q;
   logic            tx_nxt;
   logic            done_q;
   logic            done_nxt;
   logic            bit_end;
   logic            cnt_en;
   logic            cnt_clr;
   logic            ready;
   logic            accept;

   // The bit timer runs only while a frame is active. It is cleared at every bit boundary and held at zero in
   // IDLE, so the first bit after an accept always starts from zero.
   assign cnt_en  = (state != IDLE);
   assign cnt_clr = (state == IDLE) || bit_end;

   uart_baud_cnt #(
      .BAUD_COUNT (BAUD_COUNT),
      .W          (BCW)
   ) u_baud_cnt (
      .clk     (clk),
      .rst     (rst),
      .en      (cnt_en),
      .clr     (cnt_clr),
      .bit_end (bit_end)
   );

   // A new word is taken when idle, or in the last STOP clock so that frames can run back to back with no gap
   assign ready  = (state == IDLE) || ((state == STOP) && bit_end);
   assign accept = bus.tx_start && ready;

   assign bus.tx_ready = ready;
   assign bus.tx       = tx_q;
   assign bus.tx_busy  = (state != IDLE);
   assign bus.tx_done  = done_q;

   // State, shift register, bit index, line and done-pulse registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         shreg   <= shreg_nxt;
         bit_cnt <= bit_cnt_nxt;
         tx_q    <= tx_nxt;
         done_q  <= done_nxt;
      end
   end

   // Next-state and next-line logic. The line is registered, so each phase loads the value of the following bit.
   always_comb begin
      state_nxt   = state;
      shreg_nxt   = shreg;
      bit_cnt_nxt = bit_cnt;
      tx_nxt      = tx_q;
      done_nxt    = 1'b0;
      shifted     = shreg >> 1;

      case (state)
         IDLE: begin
            if (accept) begin
               shreg_nxt = bus.data_in;
               tx_nxt    = 1'b0;
               state_nxt = START;
            end
         end

         START: begin
            if (bit_end) begin
               tx_nxt      = shreg[0];
               bit_cnt_nxt = '0;
               state_nxt   = DATA;
            end
         end

         DATA: begin
            if (bit_end) begin
               if (bit_cnt == LAST_BIT) begin
                  tx_nxt    = 1'b1;
                  state_nxt = STOP;
               end else begin
                  shreg_nxt   = shifted;
                  tx_nxt      = shifted[0];
                  bit_cnt_nxt = bit_cnt + BIT_ONE;
               end
            end
         end

         STOP: begin
            if (bit_end) begin
               done_nxt = 1'b1;
               if (accept) begin
                  shreg_nxt = bus.data_in;
                  tx_nxt    = 1'b0;
                  state_nxt = START;
               end else begin
                  tx_nxt    = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end

         default: begin
            tx_nxt    = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end
endmodule
